snake_ladder_engine: RTL and testbench

Parametrised, synthesizable snakes-and-ladders game engine for N players on a configurable board. A runtime-programmable jump table holds the snakes and ladders, and a per-player FSM turn sequencer drives play. Dice come from an internal LFSR, or optionally from an external port. The block sits under the game top level and feeds position/turn status to display and scoreboard logic.

---
 rtl/snake_ladder_engine.sv | 204 ++++++++++++++++++++
 tb/tb_snake_ladder_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_ladder_engine.sv
// Snakes-and-ladders game engine: programmable jump table, per-turn sequencer, LFSR dice.
// Define SNL_EXT_DICE_EN to take dice from ext_die/ext_die_valid instead of the internal LFSR.
module snake_ladder_engine #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          BOARD_SIZE  = 64,
    parameter int          NUM_LINKS   = 8,
    parameter int          POS_W       = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           run,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_LINKS)-1:0]   cfg_idx,
    input  logic [POS_W-1:0]               cfg_from,
    input  logic [POS_W-1:0]               cfg_to,
    input  logic                           cfg_en,
`ifdef SNL_EXT_DICE_EN
    input  logic [2:0]                     ext_die,
    input  logic                           ext_die_valid,
`endif
    output logic [NUM_PLAYERS*POS_W-1:0]   positions,
    output logic [$clog2(NUM_PLAYERS)-1:0] cur_player,
    output logic [2:0]                     last_roll,
    output logic                           turn_done,
    output logic                           jumped,
    output logic                           game_over,
    output logic [$clog2(NUM_PLAYERS)-1:0] winner,
    output logic                           busy
);
    localparam int             PLW     = $clog2(NUM_PLAYERS);
    localparam int             IDXW    = $clog2(NUM_LINKS);
    localparam logic [POS_W:0] BOARD_X = (POS_W+1)'(BOARD_SIZE);
    localparam logic [IDXW:0]  LINKS_X = (IDXW+1)'(NUM_LINKS);
    localparam logic [PLW-1:0] LAST_PL = PLW'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ROLL, S_MOVE, S_LINK, S_CHECK, S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_PLAYERS-1:0][POS_W-1:0] pos_q, pos_d;
    logic [PLW-1:0]                    cur_q, cur_d, winner_q, winner_d;
    logic [2:0]                        roll_q, roll_d;
    logic                              turn_done_q, turn_done_d;
    logic                              jumped_q, jumped_d;
    logic                              jflag_q, jflag_d;
    logic                              over_q, over_d;
    logic                              busy_q, busy_d;
    logic [NUM_LINKS-1:0][POS_W-1:0]   tbl_from_q, tbl_from_d;
    logic [NUM_LINKS-1:0][POS_W-1:0]   tbl_to_q, tbl_to_d;
    logic [NUM_LINKS-1:0]              tbl_vld_q, tbl_vld_d;

    logic       die_ok;
    logic [2:0] die;
`ifdef SNL_EXT_DICE_EN
    assign die_ok = ext_die_valid && (ext_die != 3'd0) && (ext_die != 3'd7);
    assign die    = ext_die;
`else
    logic [15:0] lfsr_q, lfsr_d;
    // Right-shifting Fibonacci form of taps 16,14,13,11
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign die_ok = 1'b1;
    assign die    = 3'(lfsr_q % 16'd6) + 3'd1;
`endif

    logic [POS_W-1:0] cur_pos;
    logic [POS_W:0]   sum;
    logic             cfg_ok, cfg_open;
    logic             hit;
    logic [POS_W-1:0] hit_to;

    assign cur_pos  = pos_q[cur_q];
    assign sum      = {1'b0, cur_pos} + (POS_W+1)'(roll_q);
    assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cfg_ok   = cfg_en && (cfg_from != '0) && ({1'b0, cfg_from} < BOARD_X)
                      && ({1'b0, cfg_to} <= BOARD_X);

    // Scan from the top so the lowest matching index is the one left standing
    always_comb begin
        hit    = 1'b0;
        hit_to = '0;
        for (int i = NUM_LINKS - 1; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_from_q[i] == cur_pos)) begin
                hit    = 1'b1;
                hit_to = tbl_to_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cur_d       = cur_q;
        winner_d    = winner_q;
        roll_d      = roll_q;
        turn_done_d = 1'b0;
        jumped_d    = 1'b0;
        jflag_d     = jflag_q;
        over_d      = over_q;
        busy_d      = busy_q;
        tbl_from_d  = tbl_from_q;
        tbl_to_d    = tbl_to_q;
        tbl_vld_d   = tbl_vld_q;

        if (cfg_we && cfg_open && ({1'b0, cfg_idx} < LINKS_X)) begin
            tbl_from_d[cfg_idx] = cfg_from;
            tbl_to_d[cfg_idx]   = cfg_to;
            tbl_vld_d[cfg_idx]  = cfg_ok;
        end

        if (run) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pos_d   = '0;
                        cur_d   = '0;
                        over_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_ROLL;
                    end
                end
                S_ROLL: begin
                    if (die_ok) begin
                        roll_d  = die;
                        jflag_d = 1'b0;
                        state_d = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (sum <= BOARD_X) pos_d[cur_q] = sum[POS_W-1:0];
                    state_d = S_LINK;
                end
                S_LINK: begin
                    if (hit) begin
                        pos_d[cur_q] = hit_to;
                        jflag_d      = 1'b1;
                    end
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    turn_done_d = 1'b1;
                    jumped_d    = jflag_q;
                    if ({1'b0, cur_pos} == BOARD_X) begin
                        winner_d = cur_q;
                        over_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        if (roll_q != 3'd6) cur_d = (cur_q == LAST_PL) ? '0 : cur_q + 1'b1;
                        state_d = S_ROLL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifndef SNL_EXT_DICE_EN
        lfsr_q <= reset ? LFSR_SEED : lfsr_d;
`endif
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            cur_q       <= '0;
            winner_q    <= '0;
            roll_q      <= '0;
            turn_done_q <= 1'b0;
            jumped_q    <= 1'b0;
            jflag_q     <= 1'b0;
            over_q      <= 1'b0;
            busy_q      <= 1'b0;
            tbl_from_q  <= '0;
            tbl_to_q    <= '0;
            tbl_vld_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cur_q       <= cur_d;
            winner_q    <= winner_d;
            roll_q      <= roll_d;
            turn_done_q <= turn_done_d;
            jumped_q    <= jumped_d;
            jflag_q     <= jflag_d;
            over_q      <= over_d;
            busy_q      <= busy_d;
            tbl_from_q  <= tbl_from_d;
            tbl_to_q    <= tbl_to_d;
            tbl_vld_q   <= tbl_vld_d;
        end
    end

    assign positions  = pos_q;
    assign cur_player = cur_q;
    assign last_roll  = roll_q;
    assign turn_done  = turn_done_q;
    assign jumped     = jumped_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_snake_ladder_engine.sv
// Bench for snake_ladder_engine (LFSR dice build): turn-level game model plus literal pins.
module tb_snake_ladder_engine;
    localparam int          NP   = 2;
    localparam int          BS   = 64;
    localparam int          NL   = 8;
    localparam int          PW   = 7;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset, start, run, cfg_we, cfg_en;
    logic [2:0]    cfg_idx;
    logic [PW-1:0] cfg_from, cfg_to;
    logic [NP*PW-1:0] positions;
    logic [0:0]    cur_player, winner;
    logic [2:0]    last_roll;
    logic          turn_done, jumped, game_over, busy;

    always #5 clk = ~clk;

    snake_ladder_engine #(.NUM_PLAYERS(NP), .BOARD_SIZE(BS), .NUM_LINKS(NL),
                          .POS_W(PW), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .run(run),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_from(cfg_from), .cfg_to(cfg_to),
        .cfg_en(cfg_en), .positions(positions), .cur_player(cur_player),
        .last_roll(last_roll), .turn_done(turn_done), .jumped(jumped),
        .game_over(game_over), .winner(winner), .busy(busy));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int die_of(logic [15:0] l);
        return (int'(l) % 6) + 1;
    endfunction

    function automatic int pos_of(int p);
        return int'(positions[p*PW +: PW]);
    endfunction

    // Game model: a turn spans four running cycles; its die is taken from the LFSR
    // value current at the first of them, and its whole outcome appears at the fourth.
    logic [15:0] m_lfsr;
    int  m_pos[NP];
    int  m_cur, m_roll, m_winner, m_step;
    bit  m_active, m_over, exp_td, exp_jmp;
    int  p_die, p_new;
    bit  p_jmp;
    bit  tv[NL];
    int  tf[NL], tt[NL];

    always @(posedge clk) begin
        logic [15:0] l_old;
        l_old   = m_lfsr;
        exp_td  = 1'b0;
        exp_jmp = 1'b0;
        if (reset) begin
            m_lfsr = SEED;
            foreach (m_pos[p]) m_pos[p] = 0;
            foreach (tv[i]) tv[i] = 1'b0;
            m_cur = 0; m_roll = 0; m_winner = 0; m_step = 0;
            m_active = 1'b0; m_over = 1'b0;
        end else begin
            m_lfsr = lfsr_step(m_lfsr);
            if (!m_active && cfg_we) begin
                tv[cfg_idx] = cfg_en && (cfg_from > 0) && (cfg_from < BS) && (cfg_to <= BS);
                tf[cfg_idx] = int'(cfg_from);
                tt[cfg_idx] = int'(cfg_to);
            end
            if (run) begin
                if (!m_active) begin
                    if (start) begin
                        foreach (m_pos[p]) m_pos[p] = 0;
                        m_cur = 0; m_over = 1'b0; m_active = 1'b1; m_step = 0;
                    end
                end else begin
                    if (m_step == 0) begin
                        p_die = die_of(l_old);
                        p_new = m_pos[m_cur] + p_die;
                        if (p_new > BS) p_new = m_pos[m_cur];
                        p_jmp = 1'b0;
                        for (int i = 0; i < NL; i++)
                            if (!p_jmp && tv[i] && tf[i] == p_new) begin
                                p_jmp = 1'b1;
                                p_new = tt[i];
                            end
                    end else if (m_step == 3) begin
                        m_pos[m_cur] = p_new;
                        m_roll  = p_die;
                        exp_td  = 1'b1;
                        exp_jmp = p_jmp;
                        if (p_new == BS) begin
                            m_over = 1'b1; m_winner = m_cur; m_active = 1'b0;
                        end else if (p_die != 6) begin
                            m_cur = (m_cur + 1) % NP;
                        end
                    end
                    m_step = (m_step + 1) % 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("turn_done", int'(turn_done), int'(exp_td));
            chk("jumped", int'(jumped), int'(exp_jmp));
            chk("game_over", int'(game_over), int'(m_over));
            chk("busy", int'(busy), int'(m_active));
            chk("cur_player", int'(cur_player), m_cur);
            if (m_over) chk("winner", int'(winner), m_winner);
            if (!m_active || exp_td) begin
                for (int p = 0; p < NP; p++) chk($sformatf("pos%0d", p), pos_of(p), m_pos[p]);
                chk("last_roll", int'(last_roll), m_roll);
            end
            for (int p = 0; p < NP; p++) chk($sformatf("pos%0d_bound", p), int'(pos_of(p) <= BS), 1);
        end
    end

    task automatic wait_td(int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (turn_done) seen = 1'b1;
        end
        chk("turn_done_wait", int'(seen), 1);
    endtask

    task automatic cfg_write(int idx, int from, int to, bit en);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_from = PW'(from); cfg_to = PW'(to); cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dice_exp[7];
        logic [15:0] l;
        bit over_seen;
        dice_exp = '{2, 1, 3, 5, 3, 2, 6};
        reset = 1'b1; start = 1'b0; run = 1'b1; cfg_we = 1'b0;
        cfg_idx = '0; cfg_from = '0; cfg_to = '0; cfg_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;

        chk("rst_positions", int'(positions), 0);
        chk("rst_last_roll", int'(last_roll), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_turn_done", int'(turn_done), 0);

        // Pin the model's dice sequence from the seed
        l = SEED;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("model_die%0d", i), die_of(l), dice_exp[i]);
            l = lfsr_step(l);
        end

        // Ladder 3->35 at idx0 shadows 3->20 at idx2; idx1 has an off-board target
        reset = 1'b0;
        cfg_write(0, 3, 35, 1'b1);
        cfg_write(2, 3, 20, 1'b1);
        cfg_write(1, 10, 70, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_td(20);
        chk("t1_pos0", pos_of(0), 35);
        chk("t1_jumped", int'(jumped), 1);
        chk("t1_last_roll", int'(last_roll), 3);
        chk("t1_cur_player", int'(cur_player), 1);
        wait_td(20);
        chk("t2_pos1", pos_of(1), 35);
        chk("t2_jumped", int'(jumped), 1);
        chk("t2_cur_player", int'(cur_player), 0);

        // Play to the end with periodic pauses, ignored mid-game starts and writes
        over_seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (game_over) begin
                over_seen = 1'b1;
                break;
            end
            run    = (i % 9) != 4;
            start  = (i % 17) == 0;
            cfg_we = (i % 13) == 0;
            cfg_idx = 3'd5; cfg_from = 7'd4; cfg_to = 7'd60; cfg_en = 1'b1;
        end
        run = 1'b1; start = 1'b0; cfg_we = 1'b0;
        chk("game_over_reached", int'(over_seen), 1);

        // In DONE: table writable, positions frozen
        cfg_write(5, 3, 50, 1'b1);
        repeat (6) @(negedge clk);
        chk("done_game_over", int'(game_over), 1);

        // Second game, then reset during MOVE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_td(40);
        wait_td(40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_positions", int'(positions), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_last_roll", int'(last_roll), 0);
        chk("midrst_game_over", int'(game_over), 0);

        // Rejected entries and a cleared idx5 mean no jumps on the known first rolls
        reset = 1'b0;
        cfg_write(0, 3, 70, 1'b1);
        cfg_write(1, 0, 5, 1'b1);
        cfg_write(2, 64, 1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_td(20);
        chk("t3_pos0", pos_of(0), 3);
        chk("t3_jumped", int'(jumped), 0);
        wait_td(20);
        chk("t4_pos1", pos_of(1), 3);
        chk("t4_jumped", int'(jumped), 0);
        chk("t4_cur_player", int'(cur_player), 0);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
